grant_decoder: RTL and testbench

GRANT_DECODER -- requirements
Module: grant_decoder

---
 rtl/grant_decoder.sv | 143 ++++++++++++++
 tb/tb_grant_decoder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/grant_decoder.sv
// grant_decoder
//
// Turns an index offered by an upstream priority encoder into a registered
// one-hot grant. A grant is held until its owner signals done or drops its
// request, or until it has been held for TIMEOUT cycles, whichever comes
// first. Every grant is followed by a single GAP cycle, so there is always
// at least one idle cycle between consecutive grants.
//
// Parameters
//   TIMEOUT      maximum number of cycles gnt may stay high (2..255)
//
// Ports
//   clk          single clock, all state updates on the rising edge
//   rst_n        synchronous active-low reset
//   idx_valid    an index is offered this cycle
//   idx          offered grant index (0..7)
//   idx_ready    index is accepted this cycle (IDLE and not in reset)
//   req          live request vector
//   done         per-requester release strobe (only the owner's bit matters)
//   gnt          registered one-hot grant vector
//   owner        index of the current holder, meaningful while busy=1
//   busy         high while a grant is held
//   stray_err    one-cycle pulse after an accepted index had no live request
//   timeout_err  one-cycle pulse in the grant cycle that forces a release

module grant_decoder #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       idx_valid,
  input  logic [2:0] idx,
  output logic       idx_ready,
  input  logic [7:0] req,
  input  logic [7:0] done,
  output logic [7:0] gnt,
  output logic [2:0] owner,
  output logic       busy,
  output logic       stray_err,
  output logic       timeout_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } stateT;

  // The hold counter is 0 in the first grant cycle, so reaching TIMEOUT-1
  // means gnt has been high for exactly TIMEOUT cycles.
  localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT - 1);

  stateT      r_state;
  stateT      w_stateNext;
  logic [7:0] r_gnt;
  logic [7:0] w_gntNext;
  logic [2:0] r_owner;
  logic [2:0] w_ownerNext;
  logic [7:0] r_holdCount;
  logic [7:0] w_holdCountNext;
  logic       r_strayErr;
  logic       w_strayErrNext;
  logic       w_timeout;
  logic       w_accept;
  logic       w_release;

  // Next-state and next-output logic. Only the owner's done/req bits are
  // looked at, and only in GRANT, so foreign done strobes never matter.
  always_comb begin
    w_stateNext     = r_state;
    w_gntNext       = r_gnt;
    w_ownerNext     = r_owner;
    w_holdCountNext = r_holdCount;
    w_strayErrNext  = 1'b0;
    w_timeout       = 1'b0;
    w_accept        = (r_state == IDLE) && idx_valid;
    w_release       = done[r_owner] || !req[r_owner];

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (req[idx]) begin
            w_gntNext       = 8'(1) << idx;
            w_ownerNext     = idx;
            w_holdCountNext = 8'd0;
            w_stateNext     = GRANT;
          end else begin
            w_strayErrNext = 1'b1;
          end
        end
      end
      GRANT: begin
        // A genuine release takes priority over a coincident timeout.
        if (w_release) begin
          w_gntNext   = 8'd0;
          w_stateNext = GAP;
        end else if (r_holdCount == LAST_COUNT) begin
          w_gntNext   = 8'd0;
          w_stateNext = GAP;
          w_timeout   = 1'b1;
        end else begin
          // Only reached below LAST_COUNT, so the counter saturates there.
          w_holdCountNext = r_holdCount + 8'd1;
        end
      end
      GAP: begin
        w_gntNext   = 8'd0;
        w_stateNext = IDLE;
      end
      default: begin
        w_gntNext   = 8'd0;
        w_stateNext = IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_gnt       <= 8'd0;
      r_owner     <= 3'd0;
      r_holdCount <= 8'd0;
      r_strayErr  <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_gnt       <= w_gntNext;
      r_owner     <= w_ownerNext;
      r_holdCount <= w_holdCountNext;
      r_strayErr  <= w_strayErrNext;
    end
  end

  // timeout_err has to appear in the last grant cycle itself, so it is
  // combinational; gating with rst_n keeps a reset during that cycle silent.
  assign idx_ready   = rst_n && (r_state == IDLE);
  assign busy        = (r_state == GRANT);
  assign gnt         = r_gnt;
  assign owner       = r_owner;
  assign stray_err   = r_strayErr;
  assign timeout_err = rst_n && w_timeout;

endmodule

// File: tb/tb_grant_decoder.sv
// tb_grant_decoder
//
// Drives grant_decoder (TIMEOUT=4) with directed scenarios followed by a
// long randomized run. A behavioural model tracks who holds the grant, for
// how many cycles it has been held, and whether a cool-down cycle is due,
// and predicts every output each cycle.

module tb_grant_decoder;

  localparam int TIMEOUT = 4;

  logic       clk;
  logic       rst_n;
  logic       idx_valid;
  logic [2:0] idx;
  logic       idx_ready;
  logic [7:0] req;
  logic [7:0] done;
  logic [7:0] gnt;
  logic [2:0] owner;
  logic       busy;
  logic       stray_err;
  logic       timeout_err;

  int checkCount;
  int passCount;

  // Reference model: holder index (-1 when nobody holds), cycles held so far
  // including the current one, pending cool-down cycle, pending stray pulse.
  int mHolder;
  int mAge;
  bit mCool;
  bit mStray;

  logic lastReady;
  logic lastTimeout;

  grant_decoder #(.TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .idx_valid   (idx_valid),
    .idx         (idx),
    .idx_ready   (idx_ready),
    .req         (req),
    .done        (done),
    .gnt         (gnt),
    .owner       (owner),
    .busy        (busy),
    .stray_err   (stray_err),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts, and reports a mismatch.
  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed %0h, expected %0h at %0t",
                  tag, observed, expected, $time);
  endtask

  // Applies one cycle of inputs, checks every output against the model in
  // the middle of the cycle, then advances the model across the edge.
  task automatic applyStimulus(input logic iRst, input logic iValid,
                               input logic [2:0] iIdx, input logic [7:0] iReq,
                               input logic [7:0] iDone);
    bit         expReady;
    bit         expTimeout;
    bit         expBusy;
    bit         rel;
    logic [7:0] expGnt;
    rst_n     = iRst;
    idx_valid = iValid;
    idx       = iIdx;
    req       = iReq;
    done      = iDone;
    @(negedge clk);
    expBusy    = (mHolder >= 0);
    expGnt     = expBusy ? (8'd1 << mHolder) : 8'd0;
    rel        = expBusy && (iDone[mHolder] || !iReq[mHolder]);
    expReady   = iRst && !expBusy && !mCool;
    expTimeout = iRst && expBusy && !rel && (mAge == TIMEOUT);
    checkOutput("gnt", gnt, expGnt);
    checkOutput("busy", 8'(busy), 8'(expBusy));
    checkOutput("idx_ready", 8'(idx_ready), 8'(expReady));
    checkOutput("stray_err", 8'(stray_err), 8'(mStray));
    checkOutput("timeout_err", 8'(timeout_err), 8'(expTimeout));
    if (expBusy) checkOutput("owner", 8'(owner), 8'(mHolder));
    lastReady   = idx_ready;
    lastTimeout = timeout_err;
    @(posedge clk);
    if (!iRst) begin
      mHolder = -1;
      mAge    = 0;
      mCool   = 1'b0;
      mStray  = 1'b0;
    end else begin
      mStray = expReady && iValid && !iReq[iIdx];
      if (mHolder >= 0) begin
        if (rel || mAge == TIMEOUT) begin
          mHolder = -1;
          mCool   = 1'b1;
        end else begin
          mAge++;
        end
      end else if (mCool) begin
        mCool = 1'b0;
      end else if (iValid && iReq[iIdx]) begin
        mHolder = int'(iIdx);
        mAge    = 1;
      end
    end
    #1;
  endtask

  initial begin
    logic [7:0] rndReq;
    logic [7:0] rndDone;
    logic [2:0] rndIdx;
    logic       rndValid;
    logic       rndRst;

    checkCount = 0;
    passCount  = 0;
    mHolder    = -1;
    mAge       = 0;
    mCool      = 1'b0;
    mStray     = 1'b0;

    // Bring registers out of X before the model is trusted.
    rst_n     = 1'b0;
    idx_valid = 1'b0;
    idx       = 3'd0;
    req       = 8'd0;
    done      = 8'd0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state.
    applyStimulus(1'b0, 1'b1, 3'd1, 8'hFF, 8'h00);
    checkOutput("rst gnt", gnt, 8'h00);
    checkOutput("rst owner", 8'(owner), 8'd0);
    checkOutput("rst busy", 8'(busy), 8'd0);
    checkOutput("rst ready", 8'(lastReady), 8'd0);

    // Basic grant and release by done.
    applyStimulus(1'b1, 1'b1, 3'd4, 8'h10, 8'h00);
    checkOutput("basic gnt", gnt, 8'h10);
    checkOutput("basic owner", 8'(owner), 8'd4);
    applyStimulus(1'b1, 1'b0, 3'd0, 8'h10, 8'h10);
    checkOutput("basic release", gnt, 8'h00);
    checkOutput("basic gap ready", 8'(idx_ready), 8'd0);
    applyStimulus(1'b1, 1'b0, 3'd0, 8'h10, 8'h00);
    checkOutput("basic idle ready", 8'(idx_ready), 8'd1);

    // Stray index (no-request code).
    applyStimulus(1'b1, 1'b1, 3'd7, 8'h00, 8'h00);
    checkOutput("stray pulse", 8'(stray_err), 8'd1);
    checkOutput("stray gnt", gnt, 8'h00);
    checkOutput("stray idle", 8'(idx_ready), 8'd1);
    applyStimulus(1'b1, 1'b0, 3'd0, 8'h00, 8'h00);
    checkOutput("stray end", 8'(stray_err), 8'd0);

    // Forced release after TIMEOUT cycles.
    applyStimulus(1'b1, 1'b1, 3'd2, 8'h04, 8'h00);
    for (int k = 1; k <= TIMEOUT; k++) begin
      applyStimulus(1'b1, 1'b0, 3'd0, 8'h04, 8'h00);
      if (k < TIMEOUT) begin
        checkOutput("to hold", gnt, 8'h04);
        checkOutput("to early", 8'(lastTimeout), 8'd0);
      end
    end
    checkOutput("to pulse", 8'(lastTimeout), 8'd1);
    checkOutput("to release", gnt, 8'h00);
    checkOutput("to gap", 8'(busy), 8'd0);
    repeat (2) applyStimulus(1'b1, 1'b0, 3'd0, 8'h00, 8'h00);

    // done collides with timeout: release wins.
    applyStimulus(1'b1, 1'b1, 3'd2, 8'h04, 8'h00);
    for (int k = 1; k < TIMEOUT; k++) applyStimulus(1'b1, 1'b0, 3'd0, 8'h04, 8'h00);
    applyStimulus(1'b1, 1'b0, 3'd0, 8'h04, 8'h04);
    checkOutput("collide no to", 8'(lastTimeout), 8'd0);
    checkOutput("collide release", gnt, 8'h00);
    repeat (2) applyStimulus(1'b1, 1'b0, 3'd0, 8'h00, 8'h00);

    // Foreign done ignored, then request drop releases.
    applyStimulus(1'b1, 1'b1, 3'd3, 8'h08, 8'h00);
    applyStimulus(1'b1, 1'b0, 3'd0, 8'h08, 8'hF7);
    checkOutput("foreign hold", gnt, 8'h08);
    applyStimulus(1'b1, 1'b0, 3'd0, 8'h08, 8'hF7);
    checkOutput("foreign owner", 8'(owner), 8'd3);
    applyStimulus(1'b1, 1'b0, 3'd0, 8'h00, 8'h00);
    checkOutput("drop release", gnt, 8'h00);
    repeat (2) applyStimulus(1'b1, 1'b0, 3'd0, 8'h00, 8'h00);

    // Reset in the last grant cycle: no timeout pulse.
    applyStimulus(1'b1, 1'b1, 3'd0, 8'h01, 8'h00);
    checkOutput("rstmid gnt", gnt, 8'h01);
    for (int k = 1; k < TIMEOUT; k++) applyStimulus(1'b1, 1'b0, 3'd0, 8'h01, 8'h00);
    applyStimulus(1'b0, 1'b0, 3'd0, 8'h01, 8'h00);
    checkOutput("rstmid no to", 8'(lastTimeout), 8'd0);
    checkOutput("rstmid gnt0", gnt, 8'h00);
    checkOutput("rstmid busy", 8'(busy), 8'd0);
    checkOutput("rstmid stray", 8'(stray_err), 8'd0);
    applyStimulus(1'b1, 1'b0, 3'd0, 8'h00, 8'h00);
    checkOutput("rstmid ready", 8'(lastReady), 8'd1);

    // Randomized traffic with slowly changing requests.
    rndReq = 8'($urandom);
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 5) == 0) rndReq = 8'($urandom);
      rndIdx   = 3'($urandom_range(0, 7));
      rndValid = ($urandom_range(0, 3) != 0);
      rndDone  = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00;
      rndRst   = ($urandom_range(0, 99) != 0);
      applyStimulus(rndRst, rndValid, rndIdx, rndReq, rndDone);
    end

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
